cdb_arbiter: RTL

//  Shares the CDB_WIDTH common-data-bus broadcast slots between NUM_FU functional units.
//  The units are the ALU behind the integer RS, mul/div, branch and LSU.

---
 rtl/cdb_arbiter_pkg.sv | 25 ++
 rtl/cdb_arbiter_rr_multi_grant.sv | 48 ++++
 rtl/cdb_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU widths and the common-data-bus packet type used by the CDB arbiter,
// its grant helper and the units that consume broadcasts.
package cpu_params;
    localparam int ROB_IDX   = 6;
    localparam int PRF_IDX   = 7;
    localparam int ARF_IDX   = 5;
    localparam int XLEN      = 32;
    localparam int CDB_WIDTH = 2;
endpackage

package cdb_types;
    import cpu_params::*;

    typedef struct packed {
        logic [ROB_IDX-1:0] rob_id;
        logic [PRF_IDX-1:0] rd_phy;
        logic [ARF_IDX-1:0] rd_arch;
        logic [XLEN-1:0]    rd_value;
    } cdb_pkt_t;

    // Pointer width for n requesters; a single requester still needs one bit.
    function automatic int fu_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cdb_arbiter_rr_multi_grant.sv
// Round-robin multi-grant: picks up to CDB_WIDTH requesters starting at ptr,
// packs them into slots 0.. in scan order and returns the pointer past the last grant.
module rr_multi_grant
    import cdb_types::*;
#(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = 2,
    parameter int FU_IDX    = fu_idx_w(NUM_FU)
) (
    input  logic [NUM_FU-1:0]                 req,
    input  logic [FU_IDX-1:0]                 ptr,
    output logic [CDB_WIDTH-1:0][NUM_FU-1:0]  grant_oh,
    output logic [CDB_WIDTH-1:0]              grant_valid,
    output logic [NUM_FU-1:0]                 granted,
    output logic [FU_IDX-1:0]                 next_ptr
);

    always_comb begin
        int cnt;
        int idx;
        int last;
        grant_oh    = '0;
        grant_valid = '0;
        granted     = '0;
        next_ptr    = ptr;
        cnt         = 0;
        idx         = 0;
        last        = 0;
        for (int j = 0; j < NUM_FU; j++) begin
            // Modulo by subtraction keeps non-power-of-2 NUM_FU wrapping correctly.
            idx = int'(ptr) + j;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (req[idx] && (cnt < CDB_WIDTH)) begin
                grant_oh[cnt][idx] = 1'b1;
                grant_valid[cnt]   = 1'b1;
                granted[idx]       = 1'b1;
                last               = idx;
                cnt                = cnt + 1;
            end
        end
        if (cnt != 0) begin
            next_ptr = (last == NUM_FU - 1) ? '0 : FU_IDX'(last + 1);
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding buffer per functional unit, drained onto CDB_WIDTH
// broadcast slots each cycle in round-robin order.
module cdb_arbiter
    import cdb_types::*;
#(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = cpu_params::CDB_WIDTH,
    parameter int FU_IDX    = fu_idx_w(NUM_FU)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FU-1:0]    fu_valid,
    output logic [NUM_FU-1:0]    fu_ready,
    input  cdb_pkt_t             fu_result [NUM_FU],
    output logic [CDB_WIDTH-1:0] cdb_valid,
    output cdb_pkt_t             cdb_pkt   [CDB_WIDTH]
);

    // Handshake: an FU result transfers on a cycle where fu_valid[i] && fu_ready[i];
    // fu_ready never depends on fu_valid, and cdb_valid has no back-pressure.
    logic [NUM_FU-1:0]                hold_valid;
    cdb_pkt_t                         hold_pkt [NUM_FU];
    logic [FU_IDX-1:0]                rr_ptr;

    logic [CDB_WIDTH-1:0][NUM_FU-1:0] grant_oh;
    logic [CDB_WIDTH-1:0]             grant_valid;
    logic [NUM_FU-1:0]                granted;
    logic [FU_IDX-1:0]                next_ptr;

    rr_multi_grant #(
        .NUM_FU    (NUM_FU),
        .CDB_WIDTH (CDB_WIDTH),
        .FU_IDX    (FU_IDX)
    ) u_grant (
        .req         (hold_valid),
        .ptr         (rr_ptr),
        .grant_oh    (grant_oh),
        .grant_valid (grant_valid),
        .granted     (granted),
        .next_ptr    (next_ptr)
    );

    // A buffer being broadcast this cycle can take a new result in the same cycle.
    always_comb begin
        fu_ready = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = !rst && (!hold_valid[i] || granted[i]);
        end
    end

    // One-hot grants make an OR-mux sufficient for each slot.
    always_comb begin
        cdb_pkt_t acc;
        cdb_valid = '0;
        acc       = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            cdb_valid[k] = grant_valid[k] && !rst;
            acc          = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (grant_oh[k][i]) begin
                    acc = acc | hold_pkt[i];
                end
            end
            cdb_pkt[k] = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_pkt[i]   <= fu_result[i];
                end else if (granted[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            rr_ptr <= next_ptr;
        end
    end

endmodule
